// File: rtl/store_lane_buffer.sv
// rtl/store_lane_buffer.sv - store narrowing, byte-lane placement and write FIFO ahead of data memory
module store_lane_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_data,
    input  logic [1:0]               req_size,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     misalign,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic             legal;
    logic [31:0]      wdata_new;
    logic [3:0]       be_new;
    logic             accept;
    logic             push;
    logic             pop;

    // Ready is a pure function of occupancy so no path exists from mem_ready.
    assign req_ready = (count != CNT_W'(DEPTH));
    assign mem_valid = (count != '0);
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal;
    assign pop       = mem_valid && mem_ready;

    always_comb begin
        legal     = 1'b0;
        wdata_new = '0;
        be_new    = '0;
        case (req_size)
            2'b00: begin
                legal     = 1'b1;
                wdata_new = {4{req_data[7:0]}};
                be_new    = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                legal     = ~req_addr[0];
                wdata_new = {2{req_data[15:0]}};
                be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal     = (req_addr[1:0] == 2'b00);
                wdata_new = req_data;
                be_new    = 4'b1111;
            end
            default: begin
                legal     = 1'b0;
                wdata_new = '0;
                be_new    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= req_addr[31:2];
            data_q[wr_ptr] <= wdata_new;
            be_q[wr_ptr]   <= be_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= accept && !legal;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Stale array contents must never leak onto the bus while empty.
    assign mem_addr  = mem_valid ? {addr_q[rd_ptr], 2'b00} : '0;
    assign mem_wdata = mem_valid ? data_q[rd_ptr] : '0;
    assign mem_be    = mem_valid ? be_q[rd_ptr] : '0;
endmodule
